// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, FSM states and operand classifiers.
// Used by both the iterative multiplier and the divider.
package fp_pkg;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam logic [31:0] NINF = 32'hFF800000;
    localparam int          BIAS = 127;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    endfunction

    // Denormals count as zero: they are flushed on input.
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

endpackage

// File: rtl/mant_mul_iter.sv
// 24x24 shift-add mantissa multiplier, one multiplier bit per cycle.
// Latency 24 cycles after start; done flags the final iteration; start is only honoured by the caller when idle.
module mant_mul_iter #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);

    logic [W-1:0]   mcand_q;
    logic [W-1:0]   mplier_q;
    logic [4:0]     cnt_q;
    logic           busy_q;
    logic [2*W-1:0] prod_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            prod_q   <= '0;
        end else if (start) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            prod_q   <= '0;
        end else if (busy_q) begin
            if (mplier_q[cnt_q])
                prod_q <= prod_q + ({{W{1'b0}}, mcand_q} << cnt_q);
            if (cnt_q == 5'(W - 1)) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == 5'(W - 1));
    assign prod = prod_q;

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 single multiplier, truncating, denormals flushed to zero.
// Result 26 cycles after accept (1 for NaN/inf/zero operands); one op in flight, result held until out_ready.
module fp_mul_seq import fp_pkg::*; #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] AxB
);

    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * (MANT_W + 1);

    state_t             state_q, state_d;
    logic               sign_q;
    logic [EXP_W-1:0]   ea_q, eb_q;
    logic [31:0]        axb_q;

    logic               accept;
    logic               special;
    logic [31:0]        special_res;
    logic               eng_start, eng_busy, eng_done;
    logic [PW-1:0]      prod;
    logic [EW-1:0]      e_norm;
    logic [MANT_W-1:0]  mant_norm;
    logic               overflow, underflow;
    logic [31:0]        norm_res;

    assign accept    = in_valid && in_ready;
    assign special   = is_nan(InputA) || is_nan(InputB) || is_inf(InputA) || is_inf(InputB) ||
                       is_zero(InputA) || is_zero(InputB);
    assign eng_start = accept && !special;

    always_comb begin
        special_res = {InputA[31] ^ InputB[31], 31'h0};
        if (is_nan(InputA) || is_nan(InputB) ||
            (is_zero(InputA) && is_inf(InputB)) || (is_inf(InputA) && is_zero(InputB)))
            special_res = QNAN;
        else if (is_inf(InputA) || is_inf(InputB))
            special_res = (InputA[31] ^ InputB[31]) ? NINF : PINF;
    end

    mant_mul_iter #(.W(MANT_W + 1)) u_mant_mul_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .mcand  ({1'b1, InputA[MANT_W-1:0]}),
        .mplier ({1'b1, InputB[MANT_W-1:0]}),
        .busy   (eng_busy),
        .done   (eng_done),
        .prod   (prod)
    );

    // Product of two [1,2) mantissas lies in [1,4); the top bit selects the extra exponent step.
    assign e_norm    = {2'b00, ea_q} + {2'b00, eb_q} - EW'(BIAS) + {{(EW-1){1'b0}}, prod[PW-1]};
    assign mant_norm = MANT_W'(prod >> (prod[PW-1] ? (MANT_W + 1) : MANT_W));
    assign overflow  = !e_norm[EW-1] && (e_norm[EW-2:0] >= {1'b0, {EXP_W{1'b1}}});
    assign underflow = e_norm[EW-1] || (e_norm == '0);

    always_comb begin
        norm_res = {sign_q, e_norm[EXP_W-1:0], mant_norm};
        if (overflow)
            norm_res = sign_q ? NINF : PINF;
        else if (underflow)
            norm_res = {sign_q, 31'h0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_d = special ? DONE : MUL;
            end
            MUL: begin
                if (eng_done || !eng_busy)
                    state_d = NORM;
            end
            NORM: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
            ea_q   <= '0;
            eb_q   <= '0;
            axb_q  <= '0;
        end else begin
            if (accept) begin
                sign_q <= InputA[31] ^ InputB[31];
                ea_q   <= InputA[30:23];
                eb_q   <= InputB[30:23];
                if (special)
                    axb_q <= special_res;
            end
            if (state_q == NORM)
                axb_q <= norm_res;
        end
    end

    assign AxB = axb_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Randomised and directed bench for fp_mul_seq against an arithmetic reference model.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        out_valid, out_ready;
    logic [31:0] InputA, InputB, AxB;

    int n_chk  = 0;
    int n_fail = 0;

    fp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .InputA    (InputA),
        .InputB    (InputB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .AxB       (AxB)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
    endfunction

    // Reference product: exact integer mantissa product, then truncate and range-check.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e;
        bit     na, nb, ia, ib, za, zb;
        longint ma, mb, p, m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0);
        zb = (eb == 0);
        if (na || nb || (za && ib) || (ia && zb)) return 32'h7FC00000;
        if (ia || ib) return {s, 8'hFF, 23'h0};
        if (za || zb) return {s, 31'h0};
        ma = 64'h800000 + longint'(a[22:0]);
        mb = 64'h800000 + longint'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (longint'(1) << 47)) begin
            e = e + 1;
            m = p / (longint'(1) << 24);
        end else begin
            m = p / (longint'(1) << 23);
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), 23'(m)};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int t;
        @(negedge clk);
        InputA   = a;
        InputB   = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(output int lat);
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_hs"}, {30'h0, in_ready, out_valid}, 32'h2);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat;
        send(a, b);
        collect(lat);
        check({tag, "_val"}, AxB, ref_mul(a, b));
        check({tag, "_lat"}, 32'(lat), ref_special(a, b) ? 32'd1 : 32'd26);
        release_out(tag);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 7))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 4));
            3:       e = 8'($urandom_range(250, 254));
            default: e = 8'($urandom_range(60, 190));
        endcase
        m = ($urandom_range(0, 5) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    initial begin
        int lat;
        int stale;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        InputA    = '0;
        InputB    = '0;
        repeat (2) @(negedge clk);
        check("reset_hs", {30'h0, in_ready, out_valid}, 32'h2);
        check("reset_axb", AxB, 32'h0);
        rst = 1'b0;

        run_op(32'h40400000, 32'h40000000, "mul_3x2");
        check("mul_3x2_const", ref_mul(32'h40400000, 32'h40000000), 32'h40C00000);
        run_op(32'h3FC00000, 32'h3FC00000, "mul_1p5sq");
        run_op(32'hC0000000, 32'h3F000000, "mul_neg");
        run_op(32'h7F7FFFFF, 32'h40000000, "ovf");
        run_op(32'h00800000, 32'h3F000000, "unf");
        run_op(32'h00000000, 32'h7F800000, "zero_inf");

        // Backpressure: result must hold and a pending operand must wait.
        send(32'h40400000, 32'h40000000);
        collect(lat);
        check("bp_first_val", AxB, 32'h40C00000);
        InputA   = 32'h3F800000;
        InputB   = 32'h40400000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_axb", AxB, 32'h40C00000);
            check("bp_hold_hs", {30'h0, in_ready, out_valid}, 32'h1);
        end
        release_out("bp_release");
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect(lat);
        check("bp_second_val", AxB, 32'h40400000);
        check("bp_second_lat", 32'(lat), 32'd26);
        release_out("bp_second");

        // Reset in the middle of the multiply loop.
        send(32'h3F800000, 32'h40400000);
        repeat (10) @(negedge clk);
        check("rst_pre_hs", {30'h0, in_ready, out_valid}, 32'h0);
        rst = 1'b1;
        #1;
        check("rst_mid_hs", {30'h0, in_ready, out_valid}, 32'h2);
        check("rst_mid_axb", AxB, 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_no_stale", 32'(stale), 32'd0);
        run_op(32'h3F800000, 32'h3F800000, "post_rst_1x1");
        check("post_rst_const", ref_mul(32'h3F800000, 32'h3F800000), 32'h3F800000);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = rand_operand();
            b = rand_operand();
            run_op(a, b, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
